pwm_generator: RTL
==================

// Module: pwm_generator
// PURPOSE
//  Transmit side of the RC/ESC PWM link: converts a VALUE_WIDTH-bit throttle/servo value into a
//  fixed-period PWM frame (default 50 Hz) whose high time is 1 ms + value ticks.
//  Encoding matches the receiver measurement: a tick is DIVIDER_SIZE sys_clk cycles, and
//  MAX_COUNT ticks = 1 ms. Sits between the flight controller mixer and each motor ESC pin.
// PARAMETERS
//  VALUE_WIDTH  10    width of pwm_value
//  DIVIDER_SIZE 133   sys_clk cycles per tick (>=1)
//  MAX_COUNT    400   ticks per 1 ms; the base high time and the max value offset
//  FRAME_TICKS  8000  ticks per frame (20 ms); must be > 2*MAX_COUNT
// PORTS
//  sys_clk      in   1            system clock; all logic is on the rising edge
//  rst          in   1            synchronous, active-high reset
//  enable       in   1            1 = generate frames, 0 = idle low after the current frame
//  pwm_value    in   VALUE_WIDTH  requested offset above 1 ms, in ticks
//  value_valid  in   1            1 = load pwm_value into the pending register this cycle
//  pwm_out      out  1            registered PWM output to the ESC
//  frame_start  out  1            one-cycle strobe on the cycle pwm_out rises for a new frame
//  clamped      out  1            1 = value in the active frame was clamped to MAX_COUNT
// BEHAVIOUR
//  Reset: pwm_out=0, frame_start=0, clamped=0, state=IDLE, all counters=0, pending=0, active=0.
//   Reset takes priority over all other inputs. A reset mid-pulse drives pwm_out low on the same edge.
//  Pending/active registers: value_valid=1 writes pwm_value into pending every cycle it is high.
//   The last write wins, and no ack is produced. pending is copied to active only at frame start,
//   so the current frame never changes mid-frame.
//   If value_valid is high on the frame-start edge, the new pwm_value is used directly (bypass).
//  Clamp: if the latched value > MAX_COUNT, active=MAX_COUNT and clamped=1 for that frame.
//   Otherwise clamped=0. clamped updates only at frame start.
//  Tick prescaler: counts 0..DIVIDER_SIZE-1 and raises an internal tick at the terminal count.
//   The prescaler and the tick counter are held at 0 in IDLE and restart at 0 on every frame start.
//  FSM:
//   IDLE: pwm_out=0. If enable=1, the next edge performs frame start and moves to HIGH.
//   Frame start (edge): pwm_out<=1, frame_start<=1, active<=clamp(pending), tick counters<=0.
//   HIGH: pwm_out=1 for exactly (MAX_COUNT+active)*DIVIDER_SIZE cycles, then moves to LOW.
//    pwm_out falls on the edge where the tick count reaches MAX_COUNT+active.
//   LOW: pwm_out=0 until the frame totals FRAME_TICKS*DIVIDER_SIZE cycles from its start.
//    At frame end: if enable=1, perform frame start back to back with no gap cycle.
//    If enable=0, go to IDLE.
//  enable falling mid-frame: the current pulse and frame complete unchanged, so no runt pulse is
//   produced. enable rising during LOW of the last frame keeps the frames continuous.
//  Output timing: frame_start is high for one cycle, aligned with the first high cycle of pwm_out.
//   First frame_start comes 1 cycle after enable rises in IDLE.
//  Widths: the tick counter is wide enough for FRAME_TICKS (14 bits at default).
//   The comparison MAX_COUNT+active is computed at VALUE_WIDTH+1 bits so it never wraps.
//  Invariant: high time is always in [1 ms, 2 ms]. pwm_out never glitches, because it is a registered output.
// TESTING (benches may override DIVIDER_SIZE=2, MAX_COUNT=4, FRAME_TICKS=20 for speed;
//  the cycle counts below are for the defaults)
//  1. rst=1 for 3 cycles, enable=1 -> pwm_out=0, frame_start=0 and clamped=0 while rst is high.
//     First frame_start comes 1 cycle after rst falls.
//  2. pwm_value=0 loaded, enable=1 -> high 53,200 cycles, period 1,064,000 cycles.
//     frame_start repeats every 1,064,000 cycles.
//  3. pwm_value=200 -> high 79,800 cycles, clamped=0.
//     pwm_value=1023 -> high 106,400 cycles, clamped=1.
//  4. Write 100 at 10,000 cycles into a frame using 0 -> that frame stays high 53,200 cycles.
//     The next frame is high 66,500 cycles.
//  5. Drop enable 20,000 cycles into HIGH -> pulse still ends at 53,200 cycles.
//     pwm_out stays 0 with no further frame_start. Re-raising enable in IDLE starts a frame 1 cycle later.
//  6. Assert rst 30,000 cycles into HIGH -> pwm_out=0 on that edge. Re-enabling gives a full
//     first pulse from the pending value reset to 0 (53,200 cycles).

Source files
------------

// File: rtl/pwm_generator.sv
// pwm_generator: fixed-period RC/ESC PWM frame generator with 1 ms + value high time
module pwm_generator #(
   parameter int VALUE_WIDTH  = 10,
   parameter int DIVIDER_SIZE = 133,
   parameter int MAX_COUNT    = 400,
   parameter int FRAME_TICKS  = 8000
) (
   input  logic                   sys_clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic [VALUE_WIDTH-1:0] pwm_value,
   input  logic                   value_valid,
   output logic                   pwm_out,
   output logic                   frame_start,
   output logic                   clamped
);
   localparam int PW = $clog2(DIVIDER_SIZE + 1);
   localparam int TW = $clog2(FRAME_TICKS) + 1;
   localparam int CW = (TW > VALUE_WIDTH + 1) ? TW : VALUE_WIDTH + 1;
   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
   state_t                 state;
   logic [PW-1:0]          presc;
   logic [CW-1:0]          ticks;
   logic [CW-1:0]          tick_inc;
   logic [VALUE_WIDTH-1:0] pending;
   logic [VALUE_WIDTH-1:0] active;
   logic [VALUE_WIDTH-1:0] latch;
   logic [VALUE_WIDTH:0]   high_len;
   logic                   tick;
   logic                   over;
   logic                   high_end;
   logic                   frame_end;
   logic                   start;
   // tick/terminal-count decode and the value that a frame start would latch
   always_comb begin
      tick      = presc == PW'(DIVIDER_SIZE - 1);
      tick_inc  = ticks + 1'b1;
      high_len  = {1'b0, active} + (VALUE_WIDTH + 1)'(MAX_COUNT);
      high_end  = tick && tick_inc == CW'(high_len);
      frame_end = tick && tick_inc == CW'(FRAME_TICKS);
      latch     = value_valid ? pwm_value : pending;
      over      = {1'b0, latch} > (VALUE_WIDTH + 1)'(MAX_COUNT);
      start     = enable && (state == IDLE || (state == LOW && frame_end));
   end
   // pending register: last write wins, consumed only at frame start
   always_ff @(posedge sys_clk) begin
      if (rst) pending <= '0;
      else if (value_valid) pending <= pwm_value;
   end
   // frame FSM with registered outputs; active value frozen for the whole frame
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state       <= IDLE;
         pwm_out     <= 1'b0;
         frame_start <= 1'b0;
         clamped     <= 1'b0;
         presc       <= '0;
         ticks       <= '0;
         active      <= '0;
      end else begin
         frame_start <= 1'b0;
         if (start) begin
            state       <= HIGH;
            pwm_out     <= 1'b1;
            frame_start <= 1'b1;
            active      <= over ? VALUE_WIDTH'(MAX_COUNT) : latch;
            clamped     <= over;
            presc       <= '0;
            ticks       <= '0;
         end else if (state == IDLE) begin
            presc <= '0;
            ticks <= '0;
         end else begin
            presc <= tick ? '0 : presc + 1'b1;
            ticks <= tick ? tick_inc : ticks;
            if (state == HIGH && high_end) begin
               pwm_out <= 1'b0;
               state   <= LOW;
            end
            if (state == LOW && frame_end) begin
               state <= IDLE;
               ticks <= '0;
            end
         end
      end
   end
endmodule
